// File: rtl/axi_cdc_pkg.sv
// Shared packet layouts, widths and counter helper for the AXI CDC master-side front end.
package axi_cdc_pkg;

  localparam int unsigned AR_PKT_W = 49;
  localparam int unsigned AW_PKT_W = 49;
  localparam int unsigned W_PKT_W  = 37;
  localparam int unsigned R_PKT_W  = 43;
  localparam int unsigned B_PKT_W  = 10;
  localparam int unsigned LEN_W    = 4;
  localparam int unsigned CNT_W    = 4;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_pkt_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } aw_pkt_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_pkt_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_pkt_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } b_pkt_t;

  // Simultaneous increment and decrement leave the count unchanged.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + 1'b1;
      2'b01:   return c - 1'b1;
      default: return c;
    endcase
  endfunction

endpackage

// File: rtl/axi_resp_stage.sv
// One-entry registered pop stage: drains a FIFO read side onto a valid/ready response channel.
module axi_resp_stage
  import axi_cdc_pkg::*;
#(
  parameter int unsigned W = 43
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_fifo_not_empty,
  input  logic [W-1:0] i_fifo_data,
  output logic         o_fifo_rd_en,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_pkt
);

  logic         r_valid;
  logic [W-1:0] r_pkt;
  logic         w_pop;

  // Pop whenever the holding register is free or being drained this cycle.
  assign w_pop = i_fifo_not_empty && (!r_valid || i_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pkt   <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_pkt   <= i_fifo_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_fifo_rd_en = w_pop;
  assign o_valid      = r_valid;
  assign o_pkt        = r_pkt;

endmodule

// File: rtl/axi_cdc_master_port.sv
// Fast-domain AXI master front end: feeds AR/AW/W CDC FIFOs, drains R/B FIFOs,
// limits outstanding bursts and checks WLAST against the accepted AWLEN.
module axi_cdc_master_port
  import axi_cdc_pkg::*;
#(
  parameter int unsigned MAX_RD = 8,
  parameter int unsigned MAX_WR = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_ar_valid,
  output logic                s_ar_ready,
  input  ar_pkt_t             s_ar_pkt,
  input  logic                s_aw_valid,
  output logic                s_aw_ready,
  input  aw_pkt_t             s_aw_pkt,
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  w_pkt_t              s_w_pkt,
  output logic                s_r_valid,
  input  logic                s_r_ready,
  output r_pkt_t              s_r_pkt,
  output logic                s_b_valid,
  input  logic                s_b_ready,
  output b_pkt_t              s_b_pkt,
  output logic                AR_wr_en,
  output logic [AR_PKT_W-1:0] AR_w_data,
  input  logic                AR_not_full,
  output logic                AW_wr_en,
  output logic [AW_PKT_W-1:0] AW_w_data,
  input  logic                AW_not_full,
  output logic                W_wr_en,
  output logic [W_PKT_W-1:0]  W_w_data,
  input  logic                W_not_full,
  output logic                R_rd_en,
  input  logic [R_PKT_W-1:0]  R_r_data,
  input  logic                R_not_empty,
  output logic                B_rd_en,
  input  logic [B_PKT_W-1:0]  B_r_data,
  input  logic                B_not_empty,
  output logic [CNT_W-1:0]    rd_outstanding,
  output logic [CNT_W-1:0]    wr_outstanding,
  output logic                wlast_err
);

  localparam int unsigned PTR_W = (MAX_WR > 1) ? $clog2(MAX_WR) : 1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_WR - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [CNT_W-1:0] r_rd_cnt;
  logic [CNT_W-1:0] r_wr_cnt;
  logic [LEN_W-1:0] r_lenq [MAX_WR];
  logic [PTR_W-1:0] r_lenq_wr_ptr;
  logic [PTR_W-1:0] r_lenq_rd_ptr;
  logic [CNT_W-1:0] r_lenq_cnt;
  logic [LEN_W-1:0] r_beat_cnt;
  logic             r_wlast_err;

  logic             w_ar_hs;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_rd_dec;
  logic             w_wr_dec;
  logic             w_lenq_full;
  logic             w_lenq_empty;
  logic [LEN_W-1:0] w_lenq_head;
  logic             w_burst_end;
  logic             w_lenq_pop;

  // Address/data channels pass straight into the FIFO write sides.
  assign s_ar_ready = AR_not_full && (r_rd_cnt < CNT_W'(MAX_RD));
  assign w_ar_hs    = s_ar_valid && s_ar_ready;
  assign AR_wr_en   = w_ar_hs;
  assign AR_w_data  = s_ar_pkt;

  assign w_lenq_full  = (r_lenq_cnt == CNT_W'(MAX_WR));
  assign w_lenq_empty = (r_lenq_cnt == '0);

  assign s_aw_ready = AW_not_full && (r_wr_cnt < CNT_W'(MAX_WR)) && !w_lenq_full;
  assign w_aw_hs    = s_aw_valid && s_aw_ready;
  assign AW_wr_en   = w_aw_hs;
  assign AW_w_data  = s_aw_pkt;

  // W is gated on the registered queue count, so an AW in the same cycle does not open it.
  assign s_w_ready   = W_not_full && !w_lenq_empty;
  assign w_w_hs      = s_w_valid && s_w_ready;
  assign W_wr_en     = w_w_hs;
  assign W_w_data    = s_w_pkt;
  assign w_lenq_head = r_lenq[r_lenq_rd_ptr];
  assign w_burst_end = (r_beat_cnt == w_lenq_head);
  assign w_lenq_pop  = w_w_hs && w_burst_end;

  always_ff @(posedge clk) begin
    if (w_aw_hs) begin
      r_lenq[r_lenq_wr_ptr] <= s_aw_pkt.len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lenq_wr_ptr <= '0;
      r_lenq_rd_ptr <= '0;
      r_lenq_cnt    <= '0;
    end else begin
      if (w_aw_hs)    r_lenq_wr_ptr <= ptr_inc(r_lenq_wr_ptr);
      if (w_lenq_pop) r_lenq_rd_ptr <= ptr_inc(r_lenq_rd_ptr);
      r_lenq_cnt <= cnt_next(r_lenq_cnt, w_aw_hs, w_lenq_pop);
    end
  end

  // Beat count, not the last bit, decides where a burst ends; disagreement is only flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_wlast_err <= 1'b0;
    end else if (w_w_hs) begin
      r_beat_cnt <= w_burst_end ? '0 : r_beat_cnt + 1'b1;
      if (s_w_pkt.last != w_burst_end) r_wlast_err <= 1'b1;
    end
  end

  axi_resp_stage #(.W(R_PKT_W)) u_r_stage (
    .clk              (clk),
    .rst              (rst),
    .i_fifo_not_empty (R_not_empty),
    .i_fifo_data      (R_r_data),
    .o_fifo_rd_en     (R_rd_en),
    .o_valid          (s_r_valid),
    .i_ready          (s_r_ready),
    .o_pkt            (s_r_pkt)
  );

  axi_resp_stage #(.W(B_PKT_W)) u_b_stage (
    .clk              (clk),
    .rst              (rst),
    .i_fifo_not_empty (B_not_empty),
    .i_fifo_data      (B_r_data),
    .o_fifo_rd_en     (B_rd_en),
    .o_valid          (s_b_valid),
    .i_ready          (s_b_ready),
    .o_pkt            (s_b_pkt)
  );

  assign w_rd_dec = s_r_valid && s_r_ready && s_r_pkt.last;
  assign w_wr_dec = s_b_valid && s_b_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_rd_cnt <= cnt_next(r_rd_cnt, w_ar_hs, w_rd_dec);
      r_wr_cnt <= cnt_next(r_wr_cnt, w_aw_hs, w_wr_dec);
    end
  end

  a_rd_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(w_rd_dec && r_rd_cnt == '0));
  a_wr_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(w_wr_dec && r_wr_cnt == '0));

  assign rd_outstanding = r_rd_cnt;
  assign wr_outstanding = r_wr_cnt;
  assign wlast_err      = r_wlast_err;

endmodule
